// File: rtl/sa_out_arbiter.sv
// Round-robin, age-boosted arbiter for one router output port.
// Picks one of three held flits (L, E, N) per cycle and registers it onto the output link.
module sa_out_arbiter #(
  parameter int unsigned DATASIZE = 40,
  parameter int unsigned AGE_W    = 4,
  parameter int unsigned AGE_MAX  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          req,
  input  logic [DATASIZE-1:0] L_data_in,
  input  logic [DATASIZE-1:0] E_data_in,
  input  logic [DATASIZE-1:0] N_data_in,
  input  logic                out_full,
  output logic [2:0]          grant,
  output logic [DATASIZE-1:0] data_out,
  output logic                valid_out,
  output logic [2:0]          aged_flag
);

  localparam int unsigned NREQ = 3;
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);

  logic [1:0]          rr_ptr;
  logic [AGE_W-1:0]    age_q [NREQ];
  logic [AGE_W-1:0]    age_d [NREQ];
  logic [2:0]          aged_req;
  logic [2:0]          cand;
  logic [2:0]          rot;
  logic [2:0]          pick_rot;
  logic [1:0]          gnt_idx;
  logic [DATASIZE-1:0] sel_data;

  // Aged requesters pre-empt; otherwise every live request competes.
  always_comb begin
    aged_req = '0;
    for (int i = 0; i < NREQ; i++) begin
      aged_req[i] = req[i] && (age_q[i] == AGE_LIM);
    end
    cand = (|aged_req) ? aged_req : req;
  end

  // Rotate so the requester after rr_ptr sits in bit 0, take lowest set bit, rotate back.
  always_comb begin
    grant    = '0;
    rot      = cand;
    pick_rot = '0;
    case (rr_ptr)
      2'd0:    rot = {cand[0], cand[2], cand[1]};
      2'd1:    rot = {cand[1], cand[0], cand[2]};
      default: rot = cand;
    endcase
    pick_rot = rot & (~rot + 3'd1);
    if (rst_n && !out_full) begin
      case (rr_ptr)
        2'd0:    grant = {pick_rot[1], pick_rot[0], pick_rot[2]};
        2'd1:    grant = {pick_rot[0], pick_rot[2], pick_rot[1]};
        default: grant = pick_rot;
      endcase
    end
  end

  // Winner index and flit mux.
  always_comb begin
    gnt_idx  = 2'd0;
    sel_data = '0;
    case (grant)
      3'b001:  begin gnt_idx = 2'd0; sel_data = L_data_in; end
      3'b010:  begin gnt_idx = 2'd1; sel_data = E_data_in; end
      3'b100:  begin gnt_idx = 2'd2; sel_data = N_data_in; end
      default: begin gnt_idx = 2'd0; sel_data = '0;        end
    endcase
  end

  // Wait counters clear on withdrawal or grant and saturate at the aging threshold.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      age_d[i] = age_q[i];
      if (!req[i] || grant[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] < AGE_LIM) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      aged_flag <= '0;
      rr_ptr    <= 2'd2;
      for (int i = 0; i < NREQ; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      valid_out <= |grant;
      if (|grant) begin
        data_out <= sel_data;
        rr_ptr   <= gnt_idx;
      end
      for (int i = 0; i < NREQ; i++) begin
        age_q[i]     <= age_d[i];
        aged_flag[i] <= (age_d[i] == AGE_LIM);
      end
    end
  end

endmodule
